// File: rtl/countdown_timer.sv
// mm:ss BCD countdown: load presets minutes, cnt_en advances a TICK_DIV prescaler, one-cycle time_out at 00:00.
// Outputs registered (1-cycle latency); no backpressure, load always wins and cnt_en=0 simply pauses.
module countdown_timer #(
  parameter int TICK_DIV = 100000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cnt_en,
  input  logic       load,
  input  logic [7:0] min_Init,
  output logic       time_out,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       running
);

  localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_LOADED  = 2'd0,
    S_RUN     = 2'd1,
    S_EXPIRED = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [7:0]    r_min;
  logic [7:0]    r_sec;
  logic [PW-1:0] r_presc;
  logic          r_time_out;
  logic          r_running;

  logic [7:0]    w_min_nxt;
  logic [7:0]    w_sec_nxt;
  logic [PW-1:0] w_presc_nxt;
  logic          w_time_out_nxt;
  logic          w_expired;
  logic          w_adv;
  logic          w_tick;
  logic          w_zero;
  logic          w_last_sec;
  logic [7:0]    w_min_clamp;
  logic [7:0]    w_min_dec;
  logic [7:0]    w_sec_dec;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  // Caller guarantees v != 00, so the tens digit never underflows.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd0) begin
      r = {v[7:4] - 4'd1, 4'd9};
    end else begin
      r = {v[7:4], v[3:0] - 4'd1};
    end
    return r;
  endfunction

  assign w_expired   = (r_state == S_EXPIRED);
  assign w_adv       = cnt_en & ~load & ~w_expired;
  assign w_tick      = w_adv & (r_presc == TICK_LAST);
  assign w_zero      = (r_min == 8'h00) && (r_sec == 8'h00);
  assign w_last_sec  = (r_min == 8'h00) && (r_sec == 8'h01);
  assign w_min_clamp = {clamp_digit(min_Init[7:4]), clamp_digit(min_Init[3:0])};
  assign w_min_dec   = bcd_dec(r_min);
  assign w_sec_dec   = bcd_dec(r_sec);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_EXPIRED;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_min_nxt      = r_min;
    w_sec_nxt      = r_sec;
    w_presc_nxt    = r_presc;
    w_time_out_nxt = 1'b0;

    if (load) begin
      w_state_nxt = S_LOADED;
      w_min_nxt   = w_min_clamp;
      w_sec_nxt   = 8'h00;
      w_presc_nxt = '0;
    end else if (w_adv) begin
      w_state_nxt = S_RUN;
      w_presc_nxt = w_tick ? '0 : r_presc + PW'(1);
      if (w_tick) begin
        // A 00:00 preset expires on its first tick instead of wrapping.
        if (w_zero) begin
          w_state_nxt    = S_EXPIRED;
          w_time_out_nxt = 1'b1;
        end else if (r_sec != 8'h00) begin
          w_sec_nxt = w_sec_dec;
          if (w_last_sec) begin
            w_state_nxt    = S_EXPIRED;
            w_time_out_nxt = 1'b1;
          end
        end else begin
          w_min_nxt = w_min_dec;
          w_sec_nxt = 8'h59;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_min      <= 8'h00;
      r_sec      <= 8'h00;
      r_presc    <= '0;
      r_time_out <= 1'b0;
      r_running  <= 1'b0;
    end else begin
      r_min      <= w_min_nxt;
      r_sec      <= w_sec_nxt;
      r_presc    <= w_presc_nxt;
      r_time_out <= w_time_out_nxt;
      r_running  <= w_adv;
    end
  end

  assign time_out = r_time_out;
  assign min_bcd  = r_min;
  assign sec_bcd  = r_sec;
  assign running  = r_running;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: driver pushes per-cycle expectations from a seconds-based model,
// a monitor pops and compares after each rising edge.
module tb_countdown_timer;

  localparam int TICK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cnt_en = 1'b0;
  logic       load = 1'b0;
  logic [7:0] min_Init = 8'h00;
  logic       time_out;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic       running;

  countdown_timer #(.TICK_DIV(TICK_DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .cnt_en   (cnt_en),
    .load     (load),
    .min_Init (min_Init),
    .time_out (time_out),
    .min_bcd  (min_bcd),
    .sec_bcd  (sec_bcd),
    .running  (running)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] mn;
    logic [7:0] sc;
    logic       to;
    logic       run;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   m_total = 0;
  int   m_frac = 0;
  bit   m_exp = 1'b1;
  int   exp_pulses = 0;
  int   dut_pulses = 0;

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] b;
    b[7:4] = 4'(v / 10);
    b[3:0] = 4'(v % 10);
    return b;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, req);
  endtask

  // Model state is the time left in whole seconds plus the fraction of the current second.
  function automatic exp_t model_step(input logic r, input logic ce, input logic ld, input logic [7:0] mi);
    exp_t e;
    int t;
    int u;
    e.to = 1'b0;
    if (r) begin
      m_total = 0;
      m_frac  = 0;
      m_exp   = 1'b1;
      e.run   = 1'b0;
    end else begin
      e.run = ce && !ld && !m_exp;
      if (ld) begin
        t = int'(mi[7:4]);
        u = int'(mi[3:0]);
        if (t > 9) t = 9;
        if (u > 9) u = 9;
        m_total = (t * 10 + u) * 60;
        m_frac  = 0;
        m_exp   = 1'b0;
      end else if (ce && !m_exp) begin
        if (m_frac == TICK_DIV - 1) begin
          m_frac = 0;
          if (m_total > 0) m_total--;
          if (m_total == 0) begin
            m_exp = 1'b1;
            e.to  = 1'b1;
          end
        end else begin
          m_frac++;
        end
      end
    end
    e.mn = to_bcd(m_total / 60);
    e.sc = to_bcd(m_total % 60);
    if (e.to) exp_pulses++;
    return e;
  endfunction

  task automatic drive(input logic r, input logic ce, input logic ld, input logic [7:0] mi);
    exp_t e;
    @(negedge clk);
    rst      = r;
    cnt_en   = ce;
    load     = ld;
    min_Init = mi;
    e = model_step(r, ce, ld, mi);
    exp_q.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      if (time_out === 1'b1) dut_pulses++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("min_bcd", 32'(min_bcd), 32'(e.mn));
        check("sec_bcd", 32'(sec_bcd), 32'(e.sc));
        check("time_out", 32'(time_out), 32'(e.to));
        check("running", 32'(running), 32'(e.run));
      end
    end
  end

  initial begin
    int guard;
    logic ld;
    logic ce;
    logic rr;
    logic [7:0] mi;

    // Reset, then enable without load: stays frozen at 00:00.
    repeat (3) drive(1'b1, 1'b0, 1'b0, 8'h00);
    repeat (20) drive(1'b0, 1'b1, 1'b0, 8'h00);

    // Two-minute countdown to expiry and hold.
    drive(1'b0, 1'b0, 1'b1, 8'h02);
    repeat (530) drive(1'b0, 1'b1, 1'b0, 8'h00);

    // Pause/resume mid-second, then load in the expiring tick cycle.
    drive(1'b0, 1'b0, 1'b1, 8'h01);
    repeat (2) drive(1'b0, 1'b1, 1'b0, 8'h00);
    repeat (10) drive(1'b0, 1'b0, 1'b0, 8'h00);
    repeat (6) drive(1'b0, 1'b1, 1'b0, 8'h00);
    guard = 0;
    while (!(m_total == 1 && m_frac == TICK_DIV - 1) && guard < 2000) begin
      drive(1'b0, 1'b1, 1'b0, 8'h00);
      guard++;
    end
    drive(1'b0, 1'b1, 1'b1, 8'h03);
    repeat (8) drive(1'b0, 1'b1, 1'b0, 8'h00);

    // BCD borrows across 10:00 -> 09:59 -> ... 09:09.
    drive(1'b0, 1'b0, 1'b1, 8'h10);
    repeat (220) drive(1'b0, 1'b1, 1'b0, 8'h00);

    // Held load tracks min_Init with clamping.
    repeat (3) drive(1'b0, 1'b1, 1'b1, 8'h05);
    repeat (3) drive(1'b0, 1'b1, 1'b1, 8'h25);
    repeat (3) drive(1'b0, 1'b1, 1'b1, 8'h3C);

    // Load 00 expires on first tick; load 00 replaced on its would-be expiring tick.
    drive(1'b0, 1'b0, 1'b1, 8'h00);
    repeat (8) drive(1'b0, 1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 1'b1, 8'h00);
    repeat (3) drive(1'b0, 1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 1'b1, 8'h07);
    repeat (6) drive(1'b0, 1'b1, 1'b0, 8'h00);

    // Asynchronous reset mid-count.
    drive(1'b0, 1'b0, 1'b1, 8'h05);
    repeat (10) drive(1'b0, 1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    #1;
    check("async_rst_min", 32'(min_bcd), 32'h00);
    check("async_rst_sec", 32'(sec_bcd), 32'h00);
    check("async_rst_to", 32'(time_out), 32'h0);
    check("async_rst_run", 32'(running), 32'h0);
    repeat (6) drive(1'b0, 1'b1, 1'b0, 8'h00);

    // Randomized traffic.
    repeat (1500) begin
      rr = ($urandom_range(0, 499) == 0);
      ld = ($urandom_range(0, 39) == 0);
      ce = ($urandom_range(0, 9) != 0);
      case ($urandom_range(0, 3))
        0:       mi = 8'h00;
        1:       mi = 8'h01;
        2:       mi = 8'($urandom);
        default: mi = 8'h00;
      endcase
      drive(rr, ce, ld, mi);
    end

    @(posedge clk);
    #3;
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    check("pulse_count", 32'(dut_pulses), 32'(exp_pulses));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Countdown stage directly downstream of the work/rest state controller.
- Consumes the controller's cnt_en, load and min_Init, and keeps an mm:ss countdown in BCD.
- Returns a single-cycle time_out pulse to the controller when the count expires.
- Also drives the BCD minute/second digits to the display path.

Parameters:
- TICK_DIV, 100000000: clk cycles per 1 s tick. Bench uses 4.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- cnt_en  in  1  count enable from the state controller.
- load  in  1  preset request from the state controller; has priority over cnt_en.
- min_Init  in  8  preset minutes, two BCD digits.
- time_out  out  1  one-cycle expiry pulse to the state controller.
- min_bcd  out  8  current minutes, BCD.
- sec_bcd  out  8  current seconds, BCD.
- running  out  1  high while actively counting down.

Behaviour:
- Reset (async, rst=1): min_bcd=8'h00, sec_bcd=8'h00, prescaler=0, time_out=0, expired=1, running=0. The expired flag prevents a spurious pulse after reset.
- Internal states: LOADED (preset, not counting), RUN, EXPIRED.
  - load=1 → LOADED from any state.
  - LOADED/RUN with cnt_en=1 and load=0 → RUN.
  - RUN with cnt_en=0 → LOADED-equivalent hold. Counters are frozen, the prescaler is kept, and the state is RUN-paused.
  - Reaching expiry → EXPIRED, which is left only by load.
- Load (load=1 at an edge; cnt_en ignored):
  - Next edge sets min_bcd to min_Init, with each nibble >9 clamped to 9.
  - sec_bcd=00, prescaler=0, time_out=0, expired=0.
  - Repeats every cycle while load is held, so the value tracks a changing min_Init (SET_TIME case).
- Prescaler:
  - Counts 0..TICK_DIV-1 only when cnt_en=1, load=0 and expired=0.
  - Holds its value otherwise, so a pause keeps the fractional second.
  - Internal tick = prescaler==TICK_DIV-1 while advancing; the prescaler then wraps to 0.
- On tick, decrement (BCD):
  - sec≠00: units 0 → 9 with tens-1, else units-1.
  - sec=00 and min≠00: min BCD decrement with the same borrow rule; sec=59.
- Expiry: time_out=1 for exactly one cycle, expired set, count frozen at 00:00. This happens in either case:
  - the decrement result is 00:00 (time_out is registered on the same edge that the display shows 00:00);
  - a tick occurs with the value already 00:00 and expired=0 (the load 00 case).
- After expiry: no further decrement or pulse, regardless of cnt_en, until the next load.
- Simultaneous events: load and an expiring tick in the same cycle → load wins, no pulse.
- Latency: first decrement occurs TICK_DIV enabled cycles after counting starts.
- running = cnt_en & ~load & ~expired, registered, so it updates one cycle after its inputs.
- Range: 00:00–99:59. No binary arithmetic on the display registers; all arithmetic is per-nibble BCD.
- Reset asserted mid-count: all outputs are immediately at reset values, with no time_out pulse.

Test Plan (TICK_DIV=4):
1. Reset, then cnt_en=1 with no load for 20 cycles → min/sec stay 00/00; time_out never asserts; running=0.
2. load=1 one cycle with min_Init=8'h02, then cnt_en=1:
   - 4 cycles later the count is 01:59.
   - After 120 ticks (480 enabled cycles) it is 00:00 with time_out high exactly 1 cycle.
   - The count then holds with no further pulses for 40 cycles.
3. Pause/resume: count from 8'h01. After 2 prescaler counts drop cnt_en for 10 cycles → value unchanged; on re-enable the next decrement comes 2 cycles later, not 4.
4. BCD borrow: load 8'h10 → first tick 09:59. Continue → check 09:50→09:49 and 09:10→09:09; no 0xA–0xF digits ever appear.
5. SET_TIME: hold load=1 and cnt_en=1 while min_Init steps 8'h05→8'h25→8'h3C:
   - outputs follow as 05:00, 25:00, 39:00 (clamped);
   - no decrement; time_out=0.
6. Edge cases:
   - load 8'h00 then count → time_out on the first tick.
   - load asserted in the expiring tick cycle → no pulse; new preset taken.
   - rst pulsed mid-count → outputs 00/00 asynchronously.
